uart_tx_16bit: RTL and testbench

//  Serialises 16-bit words from the FPGA fabric onto the UART TX line of the Bluetooth module.
//  It is the outbound counterpart of the 16-bit input capture/edge-detect path.

---
 rtl/uart_tx_16bit_pkg.sv | 18 +
 rtl/uart_tx_16bit_baud.sv | 41 ++++
 rtl/uart_tx_16bit.sv | 112 +++++++++++
 tb/tb_uart_tx_16bit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_16bit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_16bit_pkg
// Description : Shared constants for the 16-bit UART transmit and receive paths.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_16bit_pkg;

    localparam int         c_default_clks_per_bit = 5208;
    localparam logic       c_uart_idle_level      = 1'b1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/uart_tx_16bit_baud.sv
`default_nettype none
// ============================================================================
// Module      : baud_tick_gen
// Description : Bit-period counter; tick marks the last enabled cycle of a bit.
// Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen
    import uart_tx_16bit_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_default_clks_per_bit
) (
    input  logic clk,
    input  logic resetn,
    input  logic e,
    input  logic clear,
    output logic tick
);

    localparam int                 c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_last;

    assign w_last = (r_cnt == c_last);
    assign tick   = e && !clear && w_last;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (e) begin
            if (clear || w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_16bit.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_16bit
// Description : Sends each accepted 16-bit word as two 8N1 frames, low byte first.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_16bit
    import uart_tx_16bit_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_default_clks_per_bit
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        e,
    input  logic [15:0] d,
    input  logic        d_valid,
    output logic        d_ready,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    logic [1:0]  r_state;
    logic [15:0] r_shreg;
    logic [2:0]  r_bit_idx;
    logic        r_byte_idx;
    logic        r_tx;
    logic        r_done;
    logic        w_tick;
    logic        w_clear;

    // Holding the counter cleared while idle lines the first bit up with acceptance.
    assign w_clear = (r_state == c_st_idle);

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .resetn (resetn),
        .e      (e),
        .clear  (w_clear),
        .tick   (w_tick)
    );

    assign d_ready = (r_state == c_st_idle);
    assign busy    = (r_state != c_st_idle);
    assign tx      = r_tx;
    assign done    = r_done;

    // The shift register moves right once per data bit, so after byte 0 the high byte sits in [7:0].
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= c_st_idle;
            r_shreg    <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= 1'b0;
            r_tx       <= c_uart_idle_level;
            r_done     <= 1'b0;
        end else if (e) begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (d_valid) begin
                        r_shreg    <= d;
                        r_state    <= c_st_start;
                        r_tx       <= 1'b0;
                        r_bit_idx  <= '0;
                        r_byte_idx <= 1'b0;
                    end
                end
                c_st_start: begin
                    if (w_tick) begin
                        r_state <= c_st_data;
                        r_tx    <= r_shreg[0];
                        r_shreg <= {1'b0, r_shreg[15:1]};
                    end
                end
                c_st_data: begin
                    if (w_tick) begin
                        if (r_bit_idx == 3'd7) begin
                            r_state   <= c_st_stop;
                            r_tx      <= c_uart_idle_level;
                            r_bit_idx <= '0;
                        end else begin
                            r_tx      <= r_shreg[0];
                            r_shreg   <= {1'b0, r_shreg[15:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                c_st_stop: begin
                    if (w_tick) begin
                        if (!r_byte_idx) begin
                            r_byte_idx <= 1'b1;
                            r_state    <= c_st_start;
                            r_tx       <= 1'b0;
                        end else begin
                            r_state <= c_st_idle;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_tx    <= c_uart_idle_level;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_16bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_16bit
// Description : Scoreboard bench: a line-level UART receiver decodes tx against a word-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_16bit;

    localparam int N          = 4;
    localparam int WORD_EDGES = 20 * N;

    logic        clk     = 1'b0;
    logic        resetn  = 1'b0;
    logic        e       = 1'b1;
    logic        d_valid = 1'b0;
    logic [15:0] d       = 16'h0000;
    logic        d_ready;
    logic        tx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_16bit #(
        .CLKS_PER_BIT (N)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .e       (e),
        .d       (d),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level reference: a word occupies exactly 20 bit periods of enabled edges.
    bit         m_idle     = 1'b1;
    bit         m_done     = 1'b0;
    int         m_left     = 0;
    int         m_accepts  = 0;
    logic [7:0] exp_q[$];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_idle <= 1'b1;
            m_done <= 1'b0;
            m_left <= 0;
            exp_q.delete();
        end else if (e) begin
            m_done <= 1'b0;
            if (m_idle) begin
                if (d_valid) begin
                    exp_q.push_back(d[7:0]);
                    exp_q.push_back(d[15:8]);
                    m_left    <= WORD_EDGES;
                    m_idle    <= 1'b0;
                    m_accepts <= m_accepts + 1;
                end
            end else begin
                if (m_left == 1) begin
                    m_idle <= 1'b1;
                    m_done <= 1'b1;
                end
                m_left <= m_left - 1;
            end
        end
    end

    // Enable driver: fixed level or random gaps.
    bit rand_e  = 1'b0;
    bit e_force = 1'b1;
    always @(negedge clk) e = rand_e ? ($urandom_range(0, 7) != 0) : e_force;

    int ecnt = 0;
    always @(posedge clk) if (resetn && e) ecnt <= ecnt + 1;

    // Handshake/status outputs against the model, every cycle.
    always @(negedge clk) begin
        chk("d_ready", {15'b0, d_ready}, {15'b0, m_idle});
        chk("busy", {15'b0, busy}, {15'b0, !m_idle});
        chk("done", {15'b0, done}, {15'b0, m_done});
        if (m_idle) chk("tx_idle", {15'b0, tx}, 16'h0001);
    end

    // Line monitor: sample each bit mid-period, counted in enabled edges from the start bit.
    bit         mon_active = 1'b0;
    int         mon_base   = 0;
    int         mon_k      = 0;
    logic [9:0] mon_fr     = '0;

    always @(negedge clk) begin
        if (!resetn) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && tx == 1'b0) begin
                mon_active = 1'b1;
                mon_base   = ecnt;
                mon_k      = 0;
            end
            if (mon_active && (ecnt - mon_base) == mon_k * N + N / 2) begin
                mon_fr[mon_k] = tx;
                mon_k++;
                if (mon_k == 10) begin
                    mon_active = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_unexpected: got frame %b expected none at %0t", mon_fr, $time);
                    end else begin
                        logic [7:0] b;
                        b = exp_q.pop_front();
                        chk("frame", {6'b0, mon_fr}, {6'b0, 1'b1, b, 1'b0});
                    end
                end
            end
        end
    end

    task automatic send(input logic [15:0] w, input bit hold_valid);
        int a0;
        int guard;
        a0    = m_accepts;
        guard = 0;
        @(negedge clk);
        #1;
        d       = w;
        d_valid = 1'b1;
        while (m_accepts == a0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (m_accepts == a0) chk("accept_timeout", 16'h0000, 16'h0001);
        if (!hold_valid) begin
            d_valid = 1'b0;
            d       = 16'($urandom);
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!m_idle && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        if (!m_idle) chk("idle_timeout", 16'h0000, 16'h0001);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_elapsed(input int k);
        int guard;
        guard = 0;
        while (!(!m_idle && (WORD_EDGES - m_left) == k) && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 4000) chk("elapsed_timeout", 16'h0000, 16'h0001);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tx", {15'b0, tx}, 16'h0001);
        chk("rst_busy", {15'b0, busy}, 16'h0000);
        chk("rst_ready", {15'b0, d_ready}, 16'h0001);
        chk("rst_done", {15'b0, done}, 16'h0000);
        #1 resetn = 1'b1;

        // Idle line with no requests.
        repeat (100) @(negedge clk);

        send(16'hA55A, 1'b0);
        wait_idle();

        // Back-to-back with d_valid held across the done cycle.
        send(16'h0001, 1'b1);
        send(16'hFFFF, 1'b0);
        wait_idle();

        // Enable dropped for 7 cycles inside bit 3 of byte 0.
        send(16'($urandom), 1'b0);
        wait_elapsed(17);
        e_force = 1'b0;
        repeat (7) @(negedge clk);
        #1 e_force = 1'b1;
        wait_idle();

        // Reset mid byte 1.
        send(16'($urandom), 1'b0);
        wait_elapsed(50);
        #1 resetn = 1'b0;
        #1;
        chk("async_tx", {15'b0, tx}, 16'h0001);
        chk("async_busy", {15'b0, busy}, 16'h0000);
        chk("async_ready", {15'b0, d_ready}, 16'h0001);
        chk("async_done", {15'b0, done}, 16'h0000);
        repeat (2) @(negedge clk);
        #1 resetn = 1'b1;
        send(16'($urandom), 1'b0);
        wait_idle();

        // Request while busy must be ignored.
        send(16'h00FF, 1'b0);
        repeat (30) @(negedge clk);
        #1;
        d       = 16'h1234;
        d_valid = 1'b1;
        @(negedge clk);
        #1 d_valid = 1'b0;
        wait_idle();

        // Random words with random enable gaps and gaps between requests.
        rand_e = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(16'($urandom), (i != 7) && ($urandom_range(0, 1) == 1));
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        wait_idle();
        rand_e = 1'b0;
        wait_idle();

        chk("queue_empty", 16'(exp_q.size()), 16'h0000);
        chk("monitor_idle", {15'b0, mon_active}, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
